clb_event_sched: RTL and testbench
==================================

CLB_EVENT_SCHED -- requirements
Module: clb_event_sched

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: FCB_CLK is the single clock, and FCB_RST is the synchronous active-high reset sampled on the FCB_CLK rising edge.
REQ-002 SHALL expose these ports:
- FCB_CLK  in  1  clock
- FCB_RST  in  1  synchronous active-high reset
- ccb_event0_i  in  4  event requests, indices 0..3
- ccb_event1_i  in  4  event requests, indices 4..7
- epwm_1a_i  in  1  sync reference
- cfg_en  in  1  scheduler enable
- cfg_sync_en  in  1  gate pulse start on epwm_1a_i rising edge
- cfg_pulse_len  in  8  pulse length in cycles
- cfg_deadband  in  4  dead time in cycles
- EPWM_2A_o  out  1  registered output A
- EPWM_2B_o  out  1  registered output B
- busy_o  out  1  state != IDLE
- grant_o  out  3  index of last granted event
- ovf_o  out  1  sticky lost-event flag

Function
REQ-003 SHALL concatenate requests as req[7:0] = {ccb_event1_i, ccb_event0_i}, registered once as req_q.
REQ-004 SHALL detect an edge on bit k when req[k]=1 and req_q[k]=0; the corresponding pending[k] SHALL be set on that same clock edge.
REQ-005 SHALL register epwm_1a_i once and define sync_ok = !cfg_sync_en | (epwm_1a_i & !epwm_1a_q).
REQ-006 SHALL implement the states IDLE, PULSE and DEAD.
REQ-007 In IDLE with pending != 0 and sync_ok=1, SHALL grant exactly one index g, clear pending[g], load grant_o=g, load the counter, and enter PULSE.
REQ-008 SHALL select g by round-robin: search starts at (grant_o+1) mod 8 and ascends with wrap; the first set pending bit wins.
REQ-009 In PULSE, SHALL drive EPWM_2A_o=1 when g is even and EPWM_2B_o=1 when g is odd, never both.
REQ-010 The pulse SHALL last max(cfg_pulse_len,1) cycles, with the values latched at grant.
REQ-011 After PULSE, SHALL enter DEAD for cfg_deadband cycles with both outputs 0; when cfg_deadband=0, SHALL go PULSE->IDLE directly.
REQ-012 Latency: edge sampled at clock edge E0 -> pending set at E0 -> grant at E1 -> output high after E1 (2 cycles) when the scheduler is idle and sync_ok holds.
REQ-013 Output A/B and busy_o SHALL be register outputs with no combinational path from inputs.
REQ-014 An edge on bit k while pending[k]=1 and k is not granted that cycle SHALL set ovf_o; ovf_o SHALL stay set until reset and the event is dropped.
REQ-015 An edge on bit g in the same cycle g is granted SHALL leave pending[g]=1 (set wins) and SHALL NOT set ovf_o.
REQ-016 Multiple simultaneous edges SHALL all be latched; they are served one per pulse in round-robin order.
REQ-017 Configuration changes during PULSE/DEAD SHALL take effect only at the next grant.
REQ-018 cfg_en=0 SHALL force the state to IDLE and the outputs to 0 on the next edge, SHALL clear pending, SHALL ignore edges, and SHALL hold ovf_o and grant_o.
REQ-019 Edge detect SHALL continue tracking req_q while cfg_en=0, so a request held high across enable does not re-trigger.

Reset
REQ-020 FCB_RST=1 SHALL set: state=IDLE, EPWM_2A_o=0, EPWM_2B_o=0, busy_o=0, pending=0, ovf_o=0, counter=0, grant_o=7 (index 0 has first priority), req_q=0, epwm_1a_q=0.
REQ-021 Because req_q resets to 0, a request already high at reset release SHALL count as an edge on the first cycle after release.
REQ-022 Reset asserted mid-PULSE or mid-DEAD SHALL take effect on the next edge with no residual pulse.

Verification
REQ-023 cfg_en=1, cfg_sync_en=0, pulse_len=3, deadband=2; ccb_event0_i[0] 0->1 -> EPWM_2A_o high 3 cycles starting 2 cycles after the edge, then 2 low cycles, grant_o=0, busy_o high for 5 cycles.
REQ-024 Simultaneous edges on indices 1, 4 and 6 after reset -> pulses in order B (1), A (4), A (6); grant_o sequence 1, 4, 6; no overflow.
REQ-025 Second edge on index 5 while pending[5] is set behind an active pulse -> ovf_o=1 and index 5 is served exactly once.
REQ-026 pulse_len=0, deadband=0 -> one-cycle pulses back-to-back, with one IDLE cycle between grants.
REQ-027 cfg_sync_en=1 with a pending event -> no pulse until an epwm_1a_i rising edge, then the pulse starts the next cycle.
REQ-028 cfg_en dropped mid-PULSE, or FCB_RST asserted mid-DEAD -> outputs 0 and state IDLE on the next edge; for FCB_RST, grant_o=7 and ovf_o=0.

Source files
------------

// File: rtl/clb_event_sched.sv
// Event pulse scheduler: latches rising edges on eight request lines and serves them
// round-robin as fixed-length pulses on EPWM_2A_o/EPWM_2B_o, each followed by a dead time.
module clb_event_sched (
  input  logic       FCB_CLK,
  input  logic       FCB_RST,
  input  logic [3:0] ccb_event0_i,
  input  logic [3:0] ccb_event1_i,
  input  logic       epwm_1a_i,
  input  logic       cfg_en,
  input  logic       cfg_sync_en,
  input  logic [7:0] cfg_pulse_len,
  input  logic [3:0] cfg_deadband,
  output logic       EPWM_2A_o,
  output logic       EPWM_2B_o,
  output logic       busy_o,
  output logic [2:0] grant_o,
  output logic       ovf_o
);

  typedef enum logic [1:0] {StIdle, StPulse, StDead} state_e;

  state_e     state_q, state_d;
  logic [7:0] req, req_q, edge_det;
  logic [7:0] pending_q, pending_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] db_q, db_d;
  logic [2:0] grant_q, grant_d;
  logic       ovf_q, ovf_d;
  logic       out_a_q, out_a_d, out_b_q, out_b_d, busy_q, busy_d;
  logic       epwm_1a_q, sync_ok;
  logic [2:0] rr_idx, rr_cand;
  logic       rr_found;
  logic       do_grant;
  logic [7:0] grant_mask;

  assign req      = {ccb_event1_i, ccb_event0_i};
  assign edge_det = req & ~req_q;
  assign sync_ok  = !cfg_sync_en | (epwm_1a_i & !epwm_1a_q);

  // Round-robin: scan upward from the index after the last grant, wrapping at 8.
  always_comb begin
    rr_idx   = grant_q;
    rr_cand  = grant_q;
    rr_found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      rr_cand = grant_q + 3'(i);
      if (!rr_found && pending_q[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    db_d       = db_q;
    grant_d    = grant_q;
    ovf_d      = ovf_q;
    do_grant   = 1'b0;
    grant_mask = '0;
    if (!cfg_en) begin
      state_d   = StIdle;
      pending_d = '0;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rr_found && sync_ok) begin
            do_grant = 1'b1;
            grant_d  = rr_idx;
            cnt_d    = (cfg_pulse_len == 8'd0) ? 8'd0 : cfg_pulse_len - 8'd1;
            db_d     = cfg_deadband;
            state_d  = StPulse;
          end
        end
        StPulse: begin
          if (cnt_q == 8'd0) begin
            if (db_q == 4'd0) begin
              state_d = StIdle;
            end else begin
              state_d = StDead;
              cnt_d   = {4'b0000, db_q - 4'd1};
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        StDead: begin
          if (cnt_q == 8'd0) state_d = StIdle;
          else               cnt_d   = cnt_q - 8'd1;
        end
        default: state_d = StIdle;
      endcase
      if (do_grant) begin
        grant_mask          = 8'b1 << rr_idx;
        pending_d[rr_idx]   = 1'b0;
      end
      // A new edge re-arms the bit being granted this cycle, so only other bits overflow.
      if ((edge_det & pending_q & ~grant_mask) != 8'd0) ovf_d = 1'b1;
      pending_d = pending_d | edge_det;
    end
    out_a_d = (state_d == StPulse) & ~grant_d[0];
    out_b_d = (state_d == StPulse) &  grant_d[0];
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge FCB_CLK) begin
    if (FCB_RST) begin
      state_q   <= StIdle;
      req_q     <= '0;
      epwm_1a_q <= 1'b0;
      pending_q <= '0;
      cnt_q     <= '0;
      db_q      <= '0;
      grant_q   <= 3'd7;
      ovf_q     <= 1'b0;
      out_a_q   <= 1'b0;
      out_b_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      epwm_1a_q <= epwm_1a_i;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      grant_q   <= grant_d;
      ovf_q     <= ovf_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      busy_q    <= busy_d;
    end
  end

  assign EPWM_2A_o = out_a_q;
  assign EPWM_2B_o = out_b_q;
  assign busy_o    = busy_q;
  assign grant_o   = grant_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_clb_event_sched.sv
// Scoreboard bench for clb_event_sched: expected pulses are queued as events are driven and
// checked by a negedge monitor; directed checks cover timing, overflow, sync, enable and reset.
module tb_clb_event_sched;

  logic       FCB_CLK = 1'b0;
  logic       FCB_RST;
  logic [3:0] ccb_event0_i, ccb_event1_i;
  logic       epwm_1a_i, cfg_en, cfg_sync_en;
  logic [7:0] cfg_pulse_len;
  logic [3:0] cfg_deadband;
  logic       EPWM_2A_o, EPWM_2B_o, busy_o, ovf_o;
  logic [2:0] grant_o;

  typedef struct {
    int idx;
    int len;
  } exp_t;

  exp_t sb_q[$];
  int   n_run = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b1;

  clb_event_sched dut (
    .FCB_CLK      (FCB_CLK),
    .FCB_RST      (FCB_RST),
    .ccb_event0_i (ccb_event0_i),
    .ccb_event1_i (ccb_event1_i),
    .epwm_1a_i    (epwm_1a_i),
    .cfg_en       (cfg_en),
    .cfg_sync_en  (cfg_sync_en),
    .cfg_pulse_len(cfg_pulse_len),
    .cfg_deadband (cfg_deadband),
    .EPWM_2A_o    (EPWM_2A_o),
    .EPWM_2B_o    (EPWM_2B_o),
    .busy_o       (busy_o),
    .grant_o      (grant_o),
    .ovf_o        (ovf_o)
  );

  always #5 FCB_CLK = ~FCB_CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int idx, input int len);
    exp_t e;
    e.idx = idx;
    e.len = len;
    sb_q.push_back(e);
  endtask

  task automatic chk_reset_state();
    chk("rst_a", int'(EPWM_2A_o), 0);
    chk("rst_b", int'(EPWM_2B_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_grant", int'(grant_o), 7);
    chk("rst_ovf", int'(ovf_o), 0);
  endtask

  task automatic do_reset();
    FCB_RST = 1'b1;
    repeat (2) @(negedge FCB_CLK);
    chk_reset_state();
    FCB_RST = 1'b0;
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard in index, side and length.
  logic act_prev = 1'b0;
  logic mon_act;
  bit   have_cur = 1'b0;
  int   run_len = 0;
  exp_t cur;

  always @(negedge FCB_CLK) begin
    mon_act = EPWM_2A_o | EPWM_2B_o;
    if (mon_en) begin
      if (mon_act) chk("ab_exclusive", int'(EPWM_2A_o & EPWM_2B_o), 0);
      if (mon_act && !act_prev) begin
        chk("pulse_expected", int'(sb_q.size() != 0), 1);
        have_cur = 1'b0;
        run_len  = 1;
        if (sb_q.size() != 0) begin
          cur      = sb_q.pop_front();
          have_cur = 1'b1;
          chk("pulse_grant", int'(grant_o), cur.idx);
          chk("pulse_side", int'({EPWM_2A_o, EPWM_2B_o}), (cur.idx % 2 == 1) ? 1 : 2);
        end
      end else if (mon_act && act_prev) begin
        run_len++;
      end else if (!mon_act && act_prev && have_cur) begin
        chk("pulse_len", run_len, cur.len);
        have_cur = 1'b0;
      end
    end
    act_prev = mon_act;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    FCB_RST       = 1'b1;
    ccb_event0_i  = '0;
    ccb_event1_i  = '0;
    epwm_1a_i     = 1'b0;
    cfg_en        = 1'b1;
    cfg_sync_en   = 1'b0;
    cfg_pulse_len = 8'd3;
    cfg_deadband  = 4'd2;
    do_reset();

    // Single event: pulse on A for 3 cycles, 2 dead cycles, 2-cycle latency.
    @(negedge FCB_CLK);
    push_exp(0, 3);
    ccb_event0_i = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      @(negedge FCB_CLK);
      chk("t1_a", int'(EPWM_2A_o), int'(c >= 1 && c <= 3));
      chk("t1_b", int'(EPWM_2B_o), 0);
      chk("t1_busy", int'(busy_o), int'(c >= 1 && c <= 5));
    end
    chk("t1_grant", int'(grant_o), 0);
    ccb_event0_i = '0;

    // Requests held high through reset count as edges; served 1, 4, 6.
    FCB_RST      = 1'b1;
    ccb_event0_i = 4'b0010;
    ccb_event1_i = 4'b0101;
    push_exp(1, 3);
    push_exp(4, 3);
    push_exp(6, 3);
    repeat (2) @(negedge FCB_CLK);
    FCB_RST = 1'b0;
    repeat (30) @(negedge FCB_CLK);
    chk("t2_drained", sb_q.size(), 0);
    chk("t2_ovf", int'(ovf_o), 0);
    chk("t2_grant", int'(grant_o), 6);
    ccb_event0_i = '0;
    ccb_event1_i = '0;

    // Second edge on index 5 while still pending: overflow, served once.
    @(negedge FCB_CLK);
    push_exp(0, 3);
    push_exp(5, 3);
    ccb_event0_i = 4'b0001;
    @(negedge FCB_CLK);
    ccb_event1_i = 4'b0010;
    @(negedge FCB_CLK);
    ccb_event1_i = 4'b0000;
    @(negedge FCB_CLK);
    ccb_event1_i = 4'b0010;
    repeat (20) @(negedge FCB_CLK);
    chk("t3_ovf", int'(ovf_o), 1);
    chk("t3_drained", sb_q.size(), 0);
    chk("t3_grant", int'(grant_o), 5);
    ccb_event0_i = '0;
    ccb_event1_i = '0;

    // Zero length and dead time: one-cycle pulses with one idle cycle between grants.
    do_reset();
    cfg_pulse_len = 8'd0;
    cfg_deadband  = 4'd0;
    push_exp(2, 1);
    push_exp(3, 1);
    ccb_event0_i = 4'b1100;
    for (int c = 0; c < 6; c++) begin
      @(negedge FCB_CLK);
      chk("t4_a", int'(EPWM_2A_o), int'(c == 1));
      chk("t4_b", int'(EPWM_2B_o), int'(c == 3));
      chk("t4_busy", int'(busy_o), int'(c == 1 || c == 3));
    end
    ccb_event0_i = '0;

    // Sync gating: pending event waits for an epwm_1a_i rising edge.
    cfg_sync_en   = 1'b1;
    cfg_pulse_len = 8'd2;
    ccb_event0_i  = 4'b0001;
    repeat (6) begin
      @(negedge FCB_CLK);
      chk("t5_wait_busy", int'(busy_o), 0);
    end
    push_exp(0, 2);
    epwm_1a_i = 1'b1;
    @(negedge FCB_CLK);
    chk("t5_a", int'(EPWM_2A_o), 1);
    chk("t5_grant", int'(grant_o), 0);
    epwm_1a_i   = 1'b0;
    cfg_sync_en = 1'b0;
    repeat (6) @(negedge FCB_CLK);
    chk("t5_drained", sb_q.size(), 0);
    ccb_event0_i = '0;

    // Enable dropped mid-pulse: outputs clear, pending dropped, held request no re-trigger.
    cfg_pulse_len = 8'd5;
    cfg_deadband  = 4'd2;
    mon_en        = 1'b0;
    @(negedge FCB_CLK);
    ccb_event0_i = 4'b0110;
    @(negedge FCB_CLK);
    @(negedge FCB_CLK);
    chk("t6_b_c1", int'(EPWM_2B_o), 1);
    @(negedge FCB_CLK);
    chk("t6_b_c2", int'(EPWM_2B_o), 1);
    cfg_en = 1'b0;
    @(negedge FCB_CLK);
    chk("t6_off_a", int'(EPWM_2A_o), 0);
    chk("t6_off_b", int'(EPWM_2B_o), 0);
    chk("t6_off_busy", int'(busy_o), 0);
    chk("t6_off_grant", int'(grant_o), 1);
    ccb_event0_i = 4'b1110;
    repeat (3) @(negedge FCB_CLK);
    mon_en = 1'b1;
    cfg_en = 1'b1;
    repeat (12) begin
      @(negedge FCB_CLK);
      chk("t6_idle_busy", int'(busy_o), 0);
    end
    chk("t6_grant_held", int'(grant_o), 1);
    ccb_event0_i = '0;

    // Reset mid-dead-time after an overflow: everything back to reset values.
    cfg_pulse_len = 8'd1;
    cfg_deadband  = 4'd4;
    @(negedge FCB_CLK);
    push_exp(4, 1);
    ccb_event1_i = 4'b0011;
    @(negedge FCB_CLK);
    ccb_event1_i = 4'b0000;
    @(negedge FCB_CLK);
    chk("t7_a", int'(EPWM_2A_o), 1);
    chk("t7_grant", int'(grant_o), 4);
    @(negedge FCB_CLK);
    chk("t7_dead_busy", int'(busy_o), 1);
    chk("t7_dead_a", int'(EPWM_2A_o), 0);
    ccb_event1_i = 4'b0010;
    @(negedge FCB_CLK);
    chk("t7_ovf", int'(ovf_o), 1);
    chk("t7_busy", int'(busy_o), 1);
    FCB_RST = 1'b1;
    @(negedge FCB_CLK);
    chk_reset_state();
    ccb_event1_i = '0;
    @(negedge FCB_CLK);
    FCB_RST = 1'b0;
    repeat (10) begin
      @(negedge FCB_CLK);
      chk("t7_post_busy", int'(busy_o), 0);
    end
    chk("t7_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
